// File: rtl/lfsr26_seq_checker.sv
// ---------------------------------------------------------------------------
// lfsr26_seq_checker
//
// Purpose:
//   Self-test monitor for a 26-bit Galois LFSR generator. Every accepted
//   generator word is compared against the one-step successor of the word
//   accepted before it. The checker acquires lock after LOCK_CNT consecutive
//   correct transitions, counts transition errors while locked, and falls
//   back to acquisition after LOSS_CNT consecutive errors.
//
// Ports:
//   clk        in   1        sole clock, rising edge
//   rst        in   1        synchronous active-high reset
//   din_valid  in   1        din carries a new generator word this cycle
//   din        in   [1:26]   generator state word (bit 26 is the feedback tap)
//   clr_cnt    in   1        synchronous clear of err_cnt
//   locked     out  1        checker is in the LOCKED state
//   err        out  1        one-cycle pulse per mismatched transition while locked
//   err_cnt    out  CNT_W    saturating count of locked-state mismatches
//   zero_det   out  1        last accepted word was all-zero
//
// All outputs are registered: they reflect the word accepted on edge k from
// just after edge k.
// ---------------------------------------------------------------------------
module lfsr26_seq_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [1:26]      din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             zero_det
);

    // The run/miss counters never hold their terminal value: the edge that
    // would reach LOCK_CNT / LOSS_CNT changes state and clears them instead,
    // so they only need to represent 0 .. N-1.
    localparam int RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int MISS_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

    typedef enum logic {
        ST_ACQ    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [1:26]       prev_q,     prev_d;
    logic              prev_vld_q, prev_vld_d;
    state_t            state_q,    state_d;
    logic [RUN_W-1:0]  run_q,      run_d;
    logic [MISS_W-1:0] miss_q,     miss_d;
    logic              err_q,      err_d;
    logic [CNT_W-1:0]  err_cnt_q,  err_cnt_d;
    logic              zero_det_q, zero_det_d;

    // -----------------------------------------------------------------------
    // Expected successor of the previous word, same taps as the generator:
    // bit 1 takes the feedback, bits 2, 8 and 9 take shift XOR feedback,
    // everything else is a plain shift toward higher bit numbers.
    // -----------------------------------------------------------------------
    logic [1:26] step_w;

    assign step_w[1] = prev_q[26];

    generate
        for (genvar gi = 2; gi <= 26; gi++) begin : g_step
            if (gi == 2 || gi == 8 || gi == 9) begin : g_tap
                assign step_w[gi] = prev_q[gi-1] ^ prev_q[26];
            end else begin : g_shift
                assign step_w[gi] = prev_q[gi-1];
            end
        end
    endgenerate

    logic din_zero;
    logic good_step;

    assign din_zero = (din == '0);

    // An all-zero word is never a good transition: the zero word is the
    // lockup state of the generator and must not be able to hold lock.
    assign good_step = prev_vld_q && (din == step_w) && !din_zero;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        state_d    = state_q;
        run_d      = run_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        zero_det_d = zero_det_q;

        // Clear first so that a coincident locked mismatch counts on top
        // of the cleared value (result is 1).
        if (clr_cnt) begin
            err_cnt_d = '0;
        end

        if (din_valid) begin
            prev_d     = din;
            prev_vld_d = 1'b1;
            zero_det_d = din_zero;

            // The first word after reset only seeds prev.
            if (prev_vld_q) begin
                case (state_q)
                    ST_ACQ: begin
                        if (good_step) begin
                            if (run_q == RUN_LAST) begin
                                state_d = ST_LOCKED;
                                run_d   = '0;
                                miss_d  = '0;
                            end else begin
                                run_d = run_q + 1'b1;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end

                    ST_LOCKED: begin
                        if (good_step) begin
                            miss_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (err_cnt_d != '1) begin
                                err_cnt_d = err_cnt_d + 1'b1;
                            end
                            if (miss_q == MISS_LAST) begin
                                state_d = ST_ACQ;
                                run_d   = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_d = ST_ACQ;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers (reset dominates valid and clear)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            state_q    <= ST_ACQ;
            run_q      <= '0;
            miss_q     <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            zero_det_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            state_q    <= state_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            zero_det_q <= zero_det_d;
        end
    end

    assign locked   = (state_q == ST_LOCKED);
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign zero_det = zero_det_q;

endmodule

// File: tb/tb_lfsr26_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr26_seq_checker
//
// Two checker instances share one input stream: dut_a with default
// parameters and dut_b with CNT_W=4, LOSS_CNT=31 (for counter saturation).
// The stimulus process advances a behavioural model for each instance and
// queues the expected outputs; a monitor on the falling edge pops and
// compares. A few scenario checkpoints compare against fixed values too.
// ---------------------------------------------------------------------------
module tb_lfsr26_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic [1:26] din;
    logic        clr_cnt;

    logic        la, ea, za, lb, eb, zb;
    logic [15:0] ca;
    logic [3:0]  cb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr26_seq_checker dut_a (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(la), .err(ea), .err_cnt(ca), .zero_det(za)
    );

    lfsr26_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(31), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(lb), .err(eb), .err_cnt(cb), .zero_det(zb)
    );

    // Words held as plain integers: spec bit i sits at integer bit 26-i, so
    // spec bit 26 is the LSB. One generator step is then a right shift with
    // the tap polynomial (spec bits 1,2,8,9) XORed in when the LSB was set.
    localparam logic [25:0] TAPS = 26'h3060000;

    function automatic logic [25:0] nxt(input logic [25:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 26'd0);
    endfunction

    typedef struct {
        logic [25:0] prev;
        bit          pv;
        bit          lk;
        int          run;
        int          miss;
        bit          err;
        int          cnt;
        bit          zd;
    } mst_t;

    typedef struct {
        bit la; bit ea; int ca; bit za;
        bit lb; bit eb; int cb; bit zb;
    } exp_t;

    mst_t ma, mb;
    exp_t exp_q[$];

    function automatic mst_t mreset();
        mst_t z;
        z.prev = '0; z.pv = 0; z.lk = 0; z.run = 0;
        z.miss = 0;  z.err = 0; z.cnt = 0; z.zd = 0;
        return z;
    endfunction

    // One clock edge of the checker's documented behaviour.
    function automatic mst_t mstep(input mst_t s, input bit r, input bit v,
                                   input logic [25:0] d, input bit clr,
                                   input int loss, input int cmax);
        mst_t n;
        bit   good;
        if (r) return mreset();
        n = s;
        n.err = 0;
        if (clr) n.cnt = 0;
        if (v) begin
            good = (d != 0) && (d == nxt(s.prev));
            if (s.pv) begin
                if (!s.lk) begin
                    n.run = good ? s.run + 1 : 0;
                    if (n.run == 4) begin
                        n.lk = 1; n.run = 0; n.miss = 0;
                    end
                end else if (good) begin
                    n.miss = 0;
                end else begin
                    n.err  = 1;
                    n.cnt  = (n.cnt + 1 > cmax) ? cmax : n.cnt + 1;
                    n.miss = s.miss + 1;
                    if (n.miss >= loss) begin
                        n.lk = 0; n.run = 0; n.miss = 0;
                    end
                end
            end
            n.prev = d;
            n.pv   = 1;
            n.zd   = (d == 0);
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle, advance both models, queue expectations for that edge.
    task automatic drive(input bit r, input bit v, input logic [25:0] d, input bit clr);
        exp_t e;
        rst = r; din_valid = v; din = d; clr_cnt = clr;
        ma = mstep(ma, r, v, d, clr, 3, 65535);
        mb = mstep(mb, r, v, d, clr, 31, 15);
        @(posedge clk);
        e.la = ma.lk; e.ea = ma.err; e.ca = ma.cnt; e.za = ma.zd;
        e.lb = mb.lk; e.eb = mb.err; e.cb = mb.cnt; e.zb = mb.zd;
        exp_q.push_back(e);
        $display("txn rst=%0b v=%0b din=%07h clr=%0b -> exp A(l=%0b e=%0b c=%0d z=%0b) B(l=%0b e=%0b c=%0d z=%0b)",
                 r, v, d, clr, e.la, e.ea, e.ca, e.za, e.lb, e.eb, e.cb, e.zb);
        #1;
    endtask

    // Non-zero word that is not the successor of the last accepted word.
    function automatic logic [25:0] unrelated(input logic [25:0] p);
        logic [25:0] w;
        w = 26'($urandom()) | 26'd1;
        if (w == nxt(p)) w = w ^ 26'd2;
        return w;
    endfunction

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin : pop_cmp
                exp_t e;
                e = exp_q.pop_front();
                chk("a_locked",   32'(la), 32'(e.la));
                chk("a_err",      32'(ea), 32'(e.ea));
                chk("a_err_cnt",  32'(ca), 32'(e.ca));
                chk("a_zero_det", 32'(za), 32'(e.za));
                chk("b_locked",   32'(lb), 32'(e.lb));
                chk("b_err",      32'(eb), 32'(e.eb));
                chk("b_err_cnt",  32'(cb), 32'(e.cb));
                chk("b_zero_det", 32'(zb), 32'(e.zb));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] gen;
        logic [25:0] w;
        ma = mreset();
        mb = mreset();

        // Reset
        drive(1, 0, '0, 0);
        drive(1, 0, '0, 0);
        chk("plan_reset_locked", 32'(la), 32'd0);
        chk("plan_reset_cnt", 32'(ca), 32'd0);

        // Lock acquisition from the word with only bit 26 set
        gen = 26'd1;
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, gen, 0);
            gen = nxt(gen);
            if (k == 4) chk("plan_not_locked_w4", 32'(la), 32'd0);
        end
        chk("plan_locked_w5", 32'(la), 32'd1);
        chk("plan_lock_cnt0", 32'(ca), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, gen, 0);
            gen = nxt(gen);
        end

        // Single-bit error on spec bit 13
        drive(0, 1, gen ^ (26'd1 << 13), 0);
        gen = nxt(gen);
        chk("plan_flip_err1", 32'(ea), 32'd1);
        drive(0, 1, gen, 0);
        gen = nxt(gen);
        chk("plan_flip_err2", 32'(ea), 32'd1);
        chk("plan_flip_cnt", 32'(ca), 32'd2);
        chk("plan_flip_locked", 32'(la), 32'd1);
        drive(0, 1, gen, 0);
        gen = nxt(gen);
        chk("plan_flip_clean", 32'(ea), 32'd0);

        // Loss of lock
        drive(0, 0, '0, 1);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, unrelated(ma.prev), 0);
            chk("plan_loss_err", 32'(ea), 32'd1);
        end
        chk("plan_loss_cnt", 32'(ca), 32'd3);
        chk("plan_loss_unlocked", 32'(la), 32'd0);
        gen = 26'($urandom()) | 26'd1;
        if (gen == nxt(ma.prev)) gen = gen ^ 26'd4;
        for (int k = 0; k <= 4; k++) begin
            drive(0, 1, gen, 0);
            gen = nxt(gen);
            if (k == 3) chk("plan_relock_early", 32'(la), 32'd0);
        end
        chk("plan_relock", 32'(la), 32'd1);

        // Saturation on the 4-bit counter, then clear coincident with a miss
        for (int k = 0; k < 20; k++) drive(0, 1, unrelated(ma.prev), 0);
        chk("plan_sat_cnt", 32'(cb), 32'd15);
        chk("plan_sat_locked", 32'(lb), 32'd1);
        drive(0, 1, unrelated(ma.prev), 1);
        chk("plan_clr_with_miss", 32'(cb), 32'd1);

        // Clean words with random idle gaps (garbage on din while idle)
        gen = 26'($urandom()) | 26'd1;
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, gen, 0);
            gen = nxt(gen);
            for (int g = $urandom_range(0, 5); g > 0; g--) drive(0, 0, 26'($urandom()), 0);
        end
        chk("plan_gap_locked", 32'(la), 32'd1);

        // Reset mid-lock beats valid and clear
        drive(1, 1, gen, 1);
        chk("plan_rst_locked", 32'(la), 32'd0);
        chk("plan_rst_cnt", 32'(cb), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, gen, 0);
            gen = nxt(gen);
        end
        chk("plan_post_rst_lock", 32'(la), 32'd1);

        // Zero lockup
        drive(1, 0, '0, 0);
        for (int k = 0; k < 10; k++) drive(0, 1, '0, 0);
        chk("plan_zero_det", 32'(za), 32'd1);
        chk("plan_zero_unlocked", 32'(la), 32'd0);
        chk("plan_zero_cnt", 32'(ca), 32'd0);

        // Randomized mix
        gen = 26'($urandom()) | 26'd1;
        for (int i = 0; i < 300; i++) begin
            int r;
            bit clr;
            r   = $urandom_range(0, 99);
            clr = ($urandom_range(0, 30) == 0);
            if (r < 10) begin
                drive(0, 0, 26'($urandom()), clr);
            end else if (r < 14) begin
                w = gen ^ (26'd1 << $urandom_range(0, 25));
                drive(0, 1, w, clr);
                gen = nxt(gen);
            end else if (r < 16) begin
                drive(0, 1, '0, clr);
            end else if (r < 17) begin
                drive(1, $urandom_range(0, 1) == 1, gen, clr);
            end else begin
                drive(0, 1, gen, clr);
                gen = nxt(gen);
            end
        end

        drive(0, 0, '0, 0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr26_seq_checker.md
Name: lfsr26_seq_checker

Overview:
- Downstream consumer of the 26-bit Galois LFSR generator. Takes the generator's parallel state word q[1:26] each time it advances and checks that every word is the correct one-step successor of the word before it.
- Acquires lock after a run of correct transitions and counts transition errors while locked. Declares loss of lock after repeated consecutive errors.
- Used as the on-chip self-test monitor for PRBS links and scrambler paths.

Parameters:
- LOCK_CNT, 4: consecutive matching transitions required to assert locked.
- LOSS_CNT, 3: consecutive mismatches while locked that force return to acquisition.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- din_valid  input  1  din holds a new generator word this cycle.
- din  input  [1:26]  generator state word, same bit numbering as the generator (bit 26 is the feedback tap).
- clr_cnt  input  1  synchronous clear of err_cnt.
- locked  output  1  checker is in LOCKED state.
- err  output  1  one-cycle pulse per mismatched transition while locked.
- err_cnt  output  [CNT_W-1:0]  saturating count of locked-state mismatches.
- zero_det  output  1  last accepted word was all-zero.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Next-state function step(s), identical to the generator:
  - n[1]=s[26]; n[2]=s[1]^s[26]; n[8]=s[7]^s[26]; n[9]=s[8]^s[26].
  - All other bits: n[i]=s[i-1].
- Internal registers: prev[1:26], prev_vld, state (ACQ or LOCKED), run counter, miss counter.
- A word is accepted on a clock edge where din_valid=1.
  - match = prev_vld && (din == step(prev)).
  - Then prev<=din and prev_vld<=1.
- Idle cycles (din_valid=0) change nothing and force err=0. Gaps between accepted words never affect the comparison.
- The first accepted word after reset only seeds prev. No compare, no counter change.
- ACQ state (reset state):
  - match: run+1. When run reaches LOCK_CNT, go to LOCKED and clear run and miss.
  - Mismatch or all-zero din: run=0.
  - err and err_cnt are never touched in ACQ.
- LOCKED state:
  - match: miss=0.
  - Mismatch (an all-zero din counts as a mismatch): err=1 for one cycle, err_cnt+1, miss+1.
  - When miss reaches LOSS_CNT, go to ACQ with run=0. locked drops on that same edge.
- err_cnt saturates at all-ones and does not wrap.
- clr_cnt:
  - With no simultaneous error: err_cnt<=0.
  - With a simultaneous locked mismatch: err_cnt<=1 (clear, then count).
- zero_det is updated on every accepted word: 1 if din==0, else 0. It holds between accepted words.
- All outputs are registered. They reflect the word accepted at edge k from just after edge k, a latency of one cycle from presentation.
- Reset values: locked=0, err=0, err_cnt=0, zero_det=0, prev=0, prev_vld=0, run=0, miss=0, state=ACQ.
- Reset asserted mid-lock clears everything on the next edge and takes priority over din_valid and clr_cnt.
- A single corrupted word always yields two mismatches: entering the bad word, then leaving it.

Test Plan:
- Lock acquisition: reset, then feed a clean generator sequence starting at the word with only bit 26 set. The next two words are bits {1,2,8,9} set, then bits {2,3,9,10} set, and so on. Required: locked rises after the 5th accepted word (1 seed + 4 matches), err never pulses, err_cnt=0.
- Single bit error: while locked, flip bit 13 of one word. Required: two err pulses on consecutive accepted words, err_cnt=2, locked stays 1, and the next clean word clears miss.
- Loss of lock: while locked, feed 3 unrelated non-zero words. Required: err pulses 3 times, err_cnt=3, locked falls on the 3rd; after a clean sequence, locked returns after 4 further matches.
- Zero lockup: feed 10 all-zero words after reset. Required: zero_det=1, locked stays 0, err_cnt=0.
- Saturation and clear: with CNT_W=4 and LOSS_CNT=31, lock, then inject 20 mismatches. Required: err_cnt holds at 15. Then assert clr_cnt coincident with a mismatch; required: err_cnt=1.
- Gaps and reset: insert 0–5 idle cycles between clean words. Required: lock is held with no errors. Then assert rst for 1 cycle mid-lock; required: all outputs 0 next cycle, and the first word after reset seeds only.
